shift_reg_univ: RTL and testbench

Parametrised universal shift register and the successor to the single-bit SISO block. It provides DEPTH stages of WIDTH bits each and four modes: hold, shift toward the high stage, shift toward the low stage, and parallel load. One block therefore covers SISO, SIPO, PISO and PIPO use. A saturating fill counter and a full flag tell downstream logic when a complete serial word has been assembled.

---
 rtl/shift_reg_pkg.sv | 11 +
 rtl/shift_stage.sv | 30 +++
 rtl/shift_reg_univ.sv | 104 ++++++++++
 tb/tb_shift_reg_univ.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_reg_pkg.sv
// Shared constants for the universal shift register: mode encoding and mode width.
package shift_reg_pkg;

    localparam int MODE_W = 2;

    localparam logic [MODE_W-1:0] MODE_HOLD = 2'b00;
    localparam logic [MODE_W-1:0] MODE_SHR  = 2'b01;
    localparam logic [MODE_W-1:0] MODE_SHL  = 2'b10;
    localparam logic [MODE_W-1:0] MODE_LOAD = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One lane-wide register of the universal shift register.
// The next value is picked by the effective mode: hold, lower neighbour, upper neighbour or parallel data.
module shift_stage
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [MODE_W-1:0] sel,
    input  logic [WIDTH-1:0]  d_lo,
    input  logic [WIDTH-1:0]  d_hi,
    input  logic [WIDTH-1:0]  d_pd,
    output logic [WIDTH-1:0]  q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            case (sel)
                MODE_SHR:  q <= d_lo;
                MODE_SHL:  q <= d_hi;
                MODE_LOAD: q <= d_pd;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/shift_reg_univ.sv
// Universal shift register (hold / shift right / shift left / parallel load) with a saturating fill counter.
// Optional rotation input i_rot is enabled by defining SHIFT_REG_UNIV_ROTATE_EN.
module shift_reg_univ
    import shift_reg_pkg::*;
#(
    parameter int WIDTH = 1,
    parameter int DEPTH = 4
) (
    input  logic                       i_clk,
    input  logic                       i_rst,
    input  logic                       i_en,
    input  logic [MODE_W-1:0]          i_mode,
`ifdef SHIFT_REG_UNIV_ROTATE_EN
    input  logic                       i_rot,
`endif
    input  logic [WIDTH-1:0]           i_sin_r,
    input  logic [WIDTH-1:0]           i_sin_l,
    input  logic [WIDTH*DEPTH-1:0]     i_pd,
    output logic [WIDTH-1:0]           o_sout_r,
    output logic [WIDTH-1:0]           o_sout_l,
    output logic [WIDTH*DEPTH-1:0]     o_pq,
    output logic [$clog2(DEPTH+1)-1:0] o_cnt,
    output logic                       o_full
);

    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEPTH);

    logic [MODE_W-1:0] sel;
    logic              rot_act;
    logic [WIDTH-1:0]  feed_r;
    logic [WIDTH-1:0]  feed_l;
    logic [WIDTH-1:0]  stg [DEPTH];
    logic [CNT_W-1:0]  cnt;

`ifdef SHIFT_REG_UNIV_ROTATE_EN
    assign rot_act = i_rot;
`else
    assign rot_act = 1'b0;
`endif

    // Disable folds into the hold mode so every stage sees a single selector.
    always_comb begin
        sel = MODE_HOLD;
        if (i_en) begin
            sel = i_mode;
        end
    end

    assign feed_r = rot_act ? stg[DEPTH-1] : i_sin_r;
    assign feed_l = rot_act ? stg[0]       : i_sin_l;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] d_lo;
        logic [WIDTH-1:0] d_hi;

        if (k == 0) begin : g_lo_edge
            assign d_lo = feed_r;
        end else begin : g_lo_mid
            assign d_lo = stg[k-1];
        end

        if (k == DEPTH-1) begin : g_hi_edge
            assign d_hi = feed_l;
        end else begin : g_hi_mid
            assign d_hi = stg[k+1];
        end

        shift_stage #(.WIDTH(WIDTH)) u_stage (
            .clk  (i_clk),
            .rst  (i_rst),
            .sel  (sel),
            .d_lo (d_lo),
            .d_hi (d_hi),
            .d_pd (i_pd[k*WIDTH +: WIDTH]),
            .q    (stg[k])
        );

        assign o_pq[k*WIDTH +: WIDTH] = stg[k];
    end

    // Rotation only recirculates existing contents, so it does not advance the fill count.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt <= '0;
        end else begin
            case (sel)
                MODE_SHR, MODE_SHL: begin
                    if (!rot_act && cnt != CNT_MAX) begin
                        cnt <= cnt + 1'b1;
                    end
                end
                MODE_LOAD: cnt <= CNT_MAX;
                default:   cnt <= cnt;
            endcase
        end
    end

    assign o_cnt    = cnt;
    assign o_full   = (cnt == CNT_MAX);
    assign o_sout_r = stg[DEPTH-1];
    assign o_sout_l = stg[0];

endmodule

// File: tb/tb_shift_reg_univ.sv
// Directed bench for shift_reg_univ: a WIDTH=1/DEPTH=4 instance and a WIDTH=8/DEPTH=3 instance.
module tb_shift_reg_univ;
    import shift_reg_pkg::*;

    logic clk = 1'b0;
    logic rst;
    int   total = 0;
    int   bad   = 0;

    always #5 clk = ~clk;

    logic              en_a, sin_r_a, sin_l_a, rot_a;
    logic [1:0]        mode_a;
    logic [3:0]        pd_a;
    logic              sout_r_a, sout_l_a, full_a;
    logic [3:0]        pq_a;
    logic [2:0]        cnt_a;

    logic              en_b;
    logic [1:0]        mode_b;
    logic [7:0]        sin_r_b, sin_l_b;
    logic [23:0]       pd_b;
    logic [7:0]        sout_r_b, sout_l_b;
    logic [23:0]       pq_b;
    logic [1:0]        cnt_b;
    logic              full_b;

    shift_reg_univ #(.WIDTH(1), .DEPTH(4)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(en_a), .i_mode(mode_a),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        .i_rot(rot_a),
`endif
        .i_sin_r(sin_r_a), .i_sin_l(sin_l_a), .i_pd(pd_a),
        .o_sout_r(sout_r_a), .o_sout_l(sout_l_a), .o_pq(pq_a),
        .o_cnt(cnt_a), .o_full(full_a)
    );

    shift_reg_univ #(.WIDTH(8), .DEPTH(3)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(en_b), .i_mode(mode_b),
`ifdef SHIFT_REG_UNIV_ROTATE_EN
        .i_rot(1'b0),
`endif
        .i_sin_r(sin_r_b), .i_sin_l(sin_l_b), .i_pd(pd_b),
        .o_sout_r(sout_r_b), .o_sout_l(sout_l_b), .o_pq(pq_b),
        .o_cnt(cnt_b), .o_full(full_b)
    );

    always @(posedge clk) begin
        if (en_a === 1'b1) begin
            assert (!$isunknown(mode_a)) else begin
                bad++;
                $error("FAIL mode_a_x observed=%b expected=known", mode_a);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst = 1'b1; en_a = 1'b0; mode_a = MODE_HOLD; sin_r_a = 1'b0; sin_l_a = 1'b0;
        rot_a = 1'b0; pd_a = '0;
        en_b = 1'b0; mode_b = MODE_HOLD; sin_r_b = '0; sin_l_b = '0; pd_b = '0;
        #1;
        tick();
        rst = 1'b0;

        // 1: load then reset
        en_a = 1'b1; mode_a = MODE_LOAD; pd_a = 4'hF;
        tick();
        chk("load_pq", 32'(pq_a), 32'hF);
        chk("load_cnt", 32'(cnt_a), 32'd4);
        rst = 1'b1; mode_a = MODE_HOLD;
        tick();
        rst = 1'b0;
        chk("rst_pq", 32'(pq_a), 32'h0);
        chk("rst_cnt", 32'(cnt_a), 32'd0);
        chk("rst_full", 32'(full_a), 32'd0);

        // 2: shift right 1,0,1,1
        mode_a = MODE_SHR;
        sin_r_a = 1'b1; tick();
        chk("shr1_cnt", 32'(cnt_a), 32'd1);
        sin_r_a = 1'b0; tick();
        sin_r_a = 1'b1; tick();
        chk("shr3_full", 32'(full_a), 32'd0);
        chk("shr3_pq", 32'(pq_a), 32'b0101);
        sin_r_a = 1'b1; tick();
        chk("shr4_pq", 32'(pq_a), 32'b1011);
        chk("shr4_cnt", 32'(cnt_a), 32'd4);
        chk("shr4_full", 32'(full_a), 32'd1);
        chk("shr4_sout_r", 32'(sout_r_a), 32'd1);
        sin_r_a = 1'b0; tick();
        chk("shr_sat_cnt", 32'(cnt_a), 32'd4);
        chk("shr_sat_pq", 32'(pq_a), 32'b0110);

        // 3: load 1001 then shift left with zeros
        mode_a = MODE_LOAD; pd_a = 4'b1001;
        tick();
        chk("shl0_sout_l", 32'(sout_l_a), 32'd1);
        mode_a = MODE_SHL; sin_l_a = 1'b0;
        tick(); chk("shl1_sout_l", 32'(sout_l_a), 32'd0);
        tick(); chk("shl2_sout_l", 32'(sout_l_a), 32'd0);
        tick(); chk("shl3_sout_l", 32'(sout_l_a), 32'd1);
        tick(); chk("shl4_sout_l", 32'(sout_l_a), 32'd0);
        chk("shl4_cnt", 32'(cnt_a), 32'd4);

        // 4: partial fill, enable-low hold, reset beats load
        rst = 1'b1; mode_a = MODE_HOLD; tick(); rst = 1'b0;
        mode_a = MODE_SHR; sin_r_a = 1'b1;
        tick(); tick();
        chk("part_pq", 32'(pq_a), 32'b0011);
        en_a = 1'b0; sin_r_a = 1'b0;
        tick(); tick(); tick();
        chk("hold_pq", 32'(pq_a), 32'b0011);
        chk("hold_cnt", 32'(cnt_a), 32'd2);
        chk("hold_full", 32'(full_a), 32'd0);
        en_a = 1'b1; mode_a = MODE_HOLD;
        tick();
        chk("mode_hold_pq", 32'(pq_a), 32'b0011);
        rst = 1'b1; mode_a = MODE_LOAD; pd_a = 4'hF;
        tick();
        rst = 1'b0; mode_a = MODE_HOLD;
        chk("rst_win_pq", 32'(pq_a), 32'h0);
        chk("rst_win_cnt", 32'(cnt_a), 32'd0);

        // 5: wide lanes
        en_b = 1'b1; mode_b = MODE_LOAD; pd_b = 24'hA1B2C3;
        tick();
        chk("b_load_pq", 32'(pq_b), 32'hA1B2C3);
        mode_b = MODE_SHR; sin_r_b = 8'h55;
        tick();
        mode_b = MODE_HOLD;
        chk("b_shr_pq", 32'(pq_b), 32'hB2C355);
        chk("b_sout_r", 32'(sout_r_b), 32'hB2);
        chk("b_sout_l", 32'(sout_l_b), 32'h55);
        chk("b_cnt", 32'(cnt_b), 32'd3);
        chk("b_full", 32'(full_b), 32'd1);
        mode_b = MODE_SHL; sin_l_b = 8'h7E;
        tick();
        mode_b = MODE_HOLD;
        chk("b_shl_pq", 32'(pq_b), 32'h7EB2C3);

`ifdef SHIFT_REG_UNIV_ROTATE_EN
        // 6: rotation
        mode_a = MODE_SHR; rot_a = 1'b1; sin_r_a = 1'b1;
        tick();
        chk("rot_empty_cnt", 32'(cnt_a), 32'd0);
        chk("rot_empty_pq", 32'(pq_a), 32'h0);
        mode_a = MODE_LOAD; pd_a = 4'b0001;
        tick();
        mode_a = MODE_SHR; sin_r_a = 1'b0;
        tick(); chk("rot1_pq", 32'(pq_a), 32'b0010);
        tick(); chk("rot2_pq", 32'(pq_a), 32'b0100);
        tick(); chk("rot3_pq", 32'(pq_a), 32'b1000);
        tick(); chk("rot4_pq", 32'(pq_a), 32'b0001);
        chk("rot_cnt", 32'(cnt_a), 32'd4);
        mode_a = MODE_SHL; sin_l_a = 1'b0;
        tick(); chk("rotl_pq", 32'(pq_a), 32'b1000);
        rot_a = 1'b0; mode_a = MODE_HOLD;
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
